// File: rtl/pll_reconfig_pkg.sv
// rtl/pll_reconfig_pkg.sv - shared states and register map for the PLL mode reconfiguration sequencer
package pll_reconfig_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_MODE,
        ST_WR_FRAC,
        ST_WR_START,
        ST_SETTLE,
        ST_WAIT_LOCK
    } state_t;

    localparam logic [5:0] REG_MODE  = 6'd0;
    localparam logic [5:0] REG_START = 6'd2;
    localparam logic [5:0] REG_FRAC  = 6'd7;

    // Mode register value selecting waitrequest mode in the reconfig IP
    localparam logic [31:0] PLL_MODE_WAITREQ = 32'd0;

endpackage

// File: rtl/pll_mode_reconfig_if.sv
// rtl/pll_mode_reconfig_if.sv - Avalon-MM management write port of the PLL reconfig IP
interface pll_mode_reconfig_if;

    logic        mgmt_write;
    logic [5:0]  mgmt_address;
    logic [31:0] mgmt_writedata;
    logic        mgmt_waitrequest;

    modport master (
        output mgmt_write,
        output mgmt_address,
        output mgmt_writedata,
        input  mgmt_waitrequest
    );

    modport slave (
        input  mgmt_write,
        input  mgmt_address,
        input  mgmt_writedata,
        output mgmt_waitrequest
    );

endinterface

// File: rtl/pll_mode_reconfig_sync_stable.sv
// rtl/pll_mode_reconfig_sync_stable.sv - multi-flop synchroniser with a hold-time stability qualifier
module sync_stable #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2,
    parameter int HOLD   = 1
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] value,
    output logic             load
);

    localparam int CW = $clog2(HOLD + 1);

    logic [STAGES-1:0][WIDTH-1:0] chain;
    logic [WIDTH-1:0]             held;
    logic [CW-1:0]                cnt;
    logic [WIDTH-1:0]             sync_out;

    assign sync_out = chain[STAGES-1];

    // cnt starts saturated so a quiet input after reset never produces a load
    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            chain <= '0;
            held  <= '0;
            cnt   <= CW'(HOLD);
        end else begin
            chain <= {chain[STAGES-2:0], d};
            if (sync_out != held) begin
                held <= sync_out;
                cnt  <= '0;
            end else if (cnt != CW'(HOLD)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign value = held;
    assign load  = (sync_out == held) && (cnt == CW'(HOLD - 1));

endmodule

// File: rtl/pll_mode_reconfig.sv
// rtl/pll_mode_reconfig.sv - sequences PLL fractional-K reconfiguration on a qualified mode request
module pll_mode_reconfig
    import pll_reconfig_pkg::*;
#(
    parameter int NUM_MODES     = 4,
    parameter int MODE_W        = $clog2(NUM_MODES),
    parameter int INIT_MODE     = 0,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int SETTLE_CYCLES = 64,
    parameter int LOCK_TIMEOUT  = 1000000
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic [MODE_W-1:0]       mode_req,
    input  logic [NUM_MODES*32-1:0] frac_table,
    input  logic                    pll_locked,
    pll_mode_reconfig_if.master     mgmt,
    output logic                    busy,
    output logic                    done,
    output logic                    lock_err,
    output logic [MODE_W-1:0]       active_mode
);

    localparam int CNT_LIM = (SETTLE_CYCLES > LOCK_TIMEOUT) ? SETTLE_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_LIM + 1);
    localparam logic [MODE_W:0] NUM_MODES_W = (MODE_W + 1)'(NUM_MODES);

    state_t              state_q, state_n;
    logic                write_q, write_n;
    logic [5:0]          addr_q, addr_n;
    logic [31:0]         data_q, data_n;
    logic                busy_q, busy_n;
    logic                done_q, done_n;
    logic                err_q, err_n;
    logic [MODE_W-1:0]   active_q, active_n;
    logic [MODE_W-1:0]   target_q, target_n;
    logic [MODE_W-1:0]   pend_q, pend_n;
    logic                pend_v_q, pend_v_n;
    logic [CNT_W-1:0]    cnt_q, cnt_n;

    logic [MODE_W-1:0]   req_value;
    logic                req_load;
    logic                req_ok;
    logic                lock_value;
    logic                lock_load;
    logic                lock_q;

    logic [31:0]         frac_sel;
    logic [5:0]          wr_addr;
    logic [31:0]         wr_data;
    state_t              wr_next;

    sync_stable #(
        .WIDTH  (MODE_W),
        .STAGES (SYNC_STAGES),
        .HOLD   (STABLE_CYCLES)
    ) u_req_sync (
        .clk_sys (clk_sys),
        .reset   (reset),
        .d       (mode_req),
        .value   (req_value),
        .load    (req_load)
    );

    sync_stable #(
        .WIDTH  (1),
        .STAGES (2),
        .HOLD   (1)
    ) u_lock_sync (
        .clk_sys (clk_sys),
        .reset   (reset),
        .d       (pll_locked),
        .value   (lock_value),
        .load    (lock_load)
    );

    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            lock_q <= 1'b0;
        end else if (lock_load) begin
            lock_q <= lock_value;
        end
    end

    // Qualification uses active_mode as it stands now, even mid-sequence
    assign req_ok = req_load && ({1'b0, req_value} < NUM_MODES_W) && (req_value != active_q);

    always_comb begin
        frac_sel = '0;
        for (int i = 0; i < NUM_MODES; i++) begin
            if (target_q == MODE_W'(i)) begin
                frac_sel = frac_table[32*i +: 32];
            end
        end
    end

    always_comb begin
        wr_addr = REG_MODE;
        wr_data = PLL_MODE_WAITREQ;
        wr_next = ST_WR_FRAC;
        case (state_q)
            ST_WR_FRAC: begin
                wr_addr = REG_FRAC;
                wr_data = frac_sel;
                wr_next = ST_WR_START;
            end
            ST_WR_START: begin
                wr_addr = REG_START;
                wr_data = 32'd0;
                wr_next = ST_SETTLE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            write_q  <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            active_q <= MODE_W'(INIT_MODE);
            target_q <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_n;
            write_q  <= write_n;
            addr_q   <= addr_n;
            data_q   <= data_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
            err_q    <= err_n;
            active_q <= active_n;
            target_q <= target_n;
            pend_q   <= pend_n;
            pend_v_q <= pend_v_n;
            cnt_q    <= cnt_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        write_n  = write_q;
        addr_n   = addr_q;
        data_n   = data_q;
        busy_n   = busy_q;
        done_n   = 1'b0;
        err_n    = err_q;
        active_n = active_q;
        target_n = target_q;
        pend_n   = pend_q;
        pend_v_n = pend_v_q;
        cnt_n    = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (pend_v_q) begin
                    target_n = pend_q;
                    pend_v_n = 1'b0;
                    busy_n   = 1'b1;
                    state_n  = ST_WR_MODE;
                end
            end
            // Each write spends one idle cycle with the strobe low before asserting it
            ST_WR_MODE, ST_WR_FRAC, ST_WR_START: begin
                if (!write_q) begin
                    write_n = 1'b1;
                    addr_n  = wr_addr;
                    data_n  = wr_data;
                end else if (!mgmt.mgmt_waitrequest) begin
                    write_n = 1'b0;
                    state_n = wr_next;
                    if (state_q == ST_WR_START) begin
                        active_n = target_q;
                        cnt_n    = '0;
                    end
                end
            end
            ST_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    cnt_n   = '0;
                    state_n = ST_WAIT_LOCK;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_q) begin
                    done_n  = 1'b1;
                    err_n   = 1'b0;
                    busy_n  = 1'b0;
                    state_n = ST_IDLE;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    err_n   = 1'b1;
                    busy_n  = 1'b0;
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // A fresh qualified request wins over the pending clear in IDLE
        if (req_ok) begin
            pend_n   = req_value;
            pend_v_n = 1'b1;
        end
    end

    assign mgmt.mgmt_write     = write_q;
    assign mgmt.mgmt_address   = addr_q;
    assign mgmt.mgmt_writedata = data_q;
    assign busy                = busy_q;
    assign done                = done_q;
    assign lock_err            = err_q;
    assign active_mode         = active_q;

endmodule

// File: tb/tb_pll_mode_reconfig.sv
// tb/tb_pll_mode_reconfig.sv - scoreboard bench for the PLL mode reconfiguration sequencer
module tb_pll_mode_reconfig;

    localparam logic [31:0] F0 = 32'd100;
    localparam logic [31:0] F1 = 32'd2971430088;
    localparam logic [31:0] F2 = 32'h0000_2222;
    localparam logic [31:0] F3 = 32'h3333_3333;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
        logic [7:0]  len;
    } exp_wr_t;

    logic         clk_sys = 1'b0;
    logic         reset;
    logic [2:0]   mode_req;
    logic [127:0] frac_table;
    logic         pll_locked;
    logic         busy;
    logic         done;
    logic         lock_err;
    logic [2:0]   active_mode;

    pll_mode_reconfig_if mgmt ();

    pll_mode_reconfig #(
        .NUM_MODES     (4),
        .MODE_W        (3),
        .INIT_MODE     (0),
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (4),
        .SETTLE_CYCLES (64),
        .LOCK_TIMEOUT  (200)
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .mode_req    (mode_req),
        .frac_table  (frac_table),
        .pll_locked  (pll_locked),
        .mgmt        (mgmt.master),
        .busy        (busy),
        .done        (done),
        .lock_err    (lock_err),
        .active_mode (active_mode)
    );

    always #10 clk_sys = ~clk_sys;

    exp_wr_t    exp_wr[$];
    logic [2:0] exp_done[$];
    int         checks   = 0;
    int         failures = 0;
    int         wr_count = 0;
    bit         busy_seen = 1'b0;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endfunction

    function automatic void push_seq(input logic [31:0] frac, input logic [7:0] frac_len, input logic [2:0] mode, input bit with_done);
        exp_wr.push_back('{addr: 6'd0, data: 32'd0, len: 8'd1});
        exp_wr.push_back('{addr: 6'd7, data: frac, len: frac_len});
        exp_wr.push_back('{addr: 6'd2, data: 32'd0, len: 8'd1});
        if (with_done) exp_done.push_back(mode);
    endfunction

    // Monitor: pops the scoreboard on each accepted write and each done pulse
    initial begin
        int          run = 0;
        bit          last_cmp = 1'b0;
        bit          prev_cmp;
        bit          stable;
        bit          gap_ok;
        logic [5:0]  cap_addr;
        logic [31:0] cap_data;
        exp_wr_t     e;
        logic [2:0]  m;
        forever begin
            @(negedge clk_sys);
            prev_cmp = last_cmp;
            last_cmp = 1'b0;
            if (!reset) begin
                run = 0;
            end else begin
                if (mgmt.mgmt_write) begin
                    if (run == 0) begin
                        cap_addr = mgmt.mgmt_address;
                        cap_data = mgmt.mgmt_writedata;
                        stable   = 1'b1;
                        gap_ok   = !prev_cmp;
                    end else if (mgmt.mgmt_address != cap_addr || mgmt.mgmt_writedata != cap_data) begin
                        stable = 1'b0;
                    end
                    run++;
                    if (!mgmt.mgmt_waitrequest) begin
                        wr_count++;
                        if (exp_wr.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_write: got addr %0d data %0d expected no write", mgmt.mgmt_address, mgmt.mgmt_writedata);
                        end else begin
                            e = exp_wr.pop_front();
                            check("wr_addr", 32'(mgmt.mgmt_address), 32'(e.addr));
                            check("wr_data", mgmt.mgmt_writedata, e.data);
                            check("wr_len", run, 32'(e.len));
                            check("wr_hold", 32'(stable), 32'd1);
                            check("wr_gap", 32'(gap_ok), 32'd1);
                        end
                        run      = 0;
                        last_cmp = 1'b1;
                    end
                end
                if (done) begin
                    if (exp_done.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done: got done with active_mode %0d expected none", active_mode);
                    end else begin
                        m = exp_done.pop_front();
                        check("done_active_mode", 32'(active_mode), 32'(m));
                        check("done_busy_low", 32'(busy), 32'd0);
                        check("done_lock_err", 32'(lock_err), 32'd0);
                    end
                end
                if (busy) busy_seen = 1'b1;
            end
        end
    end

    task automatic wait_write(input logic [5:0] a, input bit need_cmp, input string nm);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk_sys);
            if (mgmt.mgmt_write && mgmt.mgmt_address == a && (!need_cmp || !mgmt.mgmt_waitrequest)) return;
        end
        checks++;
        failures++;
        $display("FAIL %s: got no write to addr %0d expected one within 500 cycles", nm, a);
    endtask

    task automatic wait_busy(input logic lvl, input int limit, input string nm);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk_sys);
            if (busy == lvl) return;
        end
        checks++;
        failures++;
        $display("FAIL %s: got busy %0d expected %0d within %0d cycles", nm, !lvl, lvl, limit);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got no finish expected finish within 1ms");
        $fatal(1);
    end

    initial begin
        int cnt0;
        int n;
        reset      = 1'b0;
        mode_req   = 3'd0;
        pll_locked = 1'b0;
        mgmt.mgmt_waitrequest = 1'b0;
        frac_table = {F3, F2, F1, F0};

        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        check("rst_write", 32'(mgmt.mgmt_write), 32'd0);
        check("rst_addr", 32'(mgmt.mgmt_address), 32'd0);
        check("rst_data", mgmt.mgmt_writedata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_lock_err", 32'(lock_err), 32'd0);
        check("rst_active", 32'(active_mode), 32'd0);
        @(posedge clk_sys); #1 reset = 1'b1;
        repeat (5) @(posedge clk_sys);

        // Basic switch 0 -> 1, lock rising 100 cycles into the sequence
        push_seq(F1, 8'd1, 3'd1, 1'b1);
        #1 mode_req = 3'd1;
        wait_busy(1'b1, 50, "basic_start");
        repeat (100) @(posedge clk_sys);
        #1 pll_locked = 1'b1;
        wait_busy(1'b0, 1000, "basic_end");
        @(negedge clk_sys);
        check("basic_active", 32'(active_mode), 32'd1);
        check("basic_wr_left", exp_wr.size(), 32'd0);
        check("basic_done_left", exp_done.size(), 32'd0);

        // Waitrequest stall of five cycles on the FRAC write
        push_seq(F2, 8'd6, 3'd2, 1'b1);
        @(posedge clk_sys); #1 mode_req = 3'd2;
        wait_write(6'd0, 1'b1, "stall_mode_wr");
        @(posedge clk_sys); #1 mgmt.mgmt_waitrequest = 1'b1;
        repeat (6) @(posedge clk_sys);
        #1 mgmt.mgmt_waitrequest = 1'b0;
        wait_busy(1'b0, 1000, "stall_end");
        @(negedge clk_sys);
        check("stall_active", 32'(active_mode), 32'd2);

        // Two-cycle glitch to another mode must be ignored
        cnt0 = wr_count;
        busy_seen = 1'b0;
        @(posedge clk_sys); #1 mode_req = 3'd3;
        repeat (2) @(posedge clk_sys);
        #1 mode_req = 3'd2;
        repeat (30) @(posedge clk_sys);
        @(negedge clk_sys);
        check("glitch_writes", wr_count, cnt0);
        check("glitch_busy", 32'(busy_seen), 32'd0);
        check("glitch_active", 32'(active_mode), 32'd2);

        // Out-of-range then same-mode requests
        @(posedge clk_sys); #1 mode_req = 3'd5;
        repeat (30) @(posedge clk_sys);
        @(negedge clk_sys);
        check("oor_busy", 32'(busy_seen), 32'd0);
        check("oor_writes", wr_count, cnt0);
        @(posedge clk_sys); #1 mode_req = 3'd2;
        repeat (30) @(posedge clk_sys);
        @(negedge clk_sys);
        check("same_busy", 32'(busy_seen), 32'd0);
        check("same_active", 32'(active_mode), 32'd2);

        // Request 1, then 3 during SETTLE; both must run in order
        push_seq(F1, 8'd1, 3'd1, 1'b1);
        push_seq(F3, 8'd1, 3'd3, 1'b1);
        @(posedge clk_sys); #1 mode_req = 3'd1;
        wait_write(6'd2, 1'b1, "queue_first_start");
        repeat (10) @(posedge clk_sys);
        #1 mode_req = 3'd3;
        n = 0;
        while (!(exp_done.size() == 0 && busy == 1'b0) && n < 2000) begin
            @(negedge clk_sys);
            n++;
        end
        check("queue_in_time", 32'(n < 2000), 32'd1);
        check("queue_active", 32'(active_mode), 32'd3);
        check("queue_wr_left", exp_wr.size(), 32'd0);

        // Lock never returns: timeout after SETTLE + LOCK_TIMEOUT cycles
        @(posedge clk_sys); #1 pll_locked = 1'b0;
        repeat (10) @(posedge clk_sys);
        push_seq(F0, 8'd1, 3'd0, 1'b0);
        #1 mode_req = 3'd0;
        wait_write(6'd2, 1'b1, "timeout_start");
        n = 0;
        while (busy && n < 1000) begin
            @(negedge clk_sys);
            n++;
        end
        check("timeout_cycles", n, 32'd265);
        check("timeout_lock_err", 32'(lock_err), 32'd1);
        check("timeout_active", 32'(active_mode), 32'd0);

        // Reset asserted while the FRAC write is stalled
        exp_wr.push_back('{addr: 6'd0, data: 32'd0, len: 8'd1});
        @(posedge clk_sys); #1 mode_req = 3'd2;
        wait_write(6'd0, 1'b1, "reset_mode_wr");
        @(posedge clk_sys); #1 mgmt.mgmt_waitrequest = 1'b1;
        wait_write(6'd7, 1'b0, "reset_frac_wr");
        #1;
        reset    = 1'b0;
        mode_req = 3'd0;
        mgmt.mgmt_waitrequest = 1'b0;
        #1;
        check("reset_write", 32'(mgmt.mgmt_write), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_active", 32'(active_mode), 32'd0);
        check("reset_lock_err", 32'(lock_err), 32'd0);
        check("reset_addr", 32'(mgmt.mgmt_address), 32'd0);
        @(posedge clk_sys); #1 reset = 1'b1;
        busy_seen = 1'b0;
        cnt0 = wr_count;
        repeat (40) @(posedge clk_sys);
        @(negedge clk_sys);
        check("post_reset_busy", 32'(busy_seen), 32'd0);
        check("post_reset_writes", wr_count, cnt0);
        check("final_wr_left", exp_wr.size(), 32'd0);
        check("final_done_left", exp_done.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
